fp_div: RTL and testbench

Sequential single-precision IEEE-754 divider producing `out = a / b`. It is the multiplicative counterpart to the combinational adder/subtractor in the floating-point datapath. It uses restoring mantissa division with one quotient bit per cycle. Operands and result move over valid/ready handshakes so the block can sit between pipeline stages of the FP unit.

---
 rtl/fp_div.sv | 161 ++++++++++++++++
 tb/tb_fp_div.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fp_div.sv
// Sequential IEEE-754 single-precision divider: out = a / b.
// Restoring mantissa division, one quotient bit per cycle, valid/ready on both sides.
module fp_div #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  div_by_zero
);

  localparam logic [31:0] QNaN = 32'h7FC0_0000;

  typedef enum logic [1:0] {StIdle, StDiv, StNorm, StDone} state_e;

  state_e      state_q, state_d;
  logic [24:0] rem_q, rem_d;
  logic [24:0] mb_q, mb_d;
  logic [24:0] q_q, q_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic [7:0]  ea_q, ea_d;
  logic [7:0]  eb_q, eb_d;
  logic [31:0] out_q, out_d;
  logic        out_valid_q, out_valid_d;
  logic        dbz_q, dbz_d;

  // Operand classification on the raw inputs; denormals count as zero.
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, in_sign;
  assign a_zero  = (a[30:23] == 8'd0);
  assign b_zero  = (b[30:23] == 8'd0);
  assign a_inf   = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
  assign b_inf   = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
  assign a_nan   = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  assign b_nan   = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  assign in_sign = a[31] ^ b[31];

  logic signed [9:0] e;
  logic [22:0]       frac;
  logic [24:0]       rem_sub;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    mb_d        = mb_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    ea_d        = ea_q;
    eb_d        = eb_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    dbz_d       = dbz_q;
    e           = '0;
    frac        = '0;
    rem_sub     = rem_q - mb_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d = in_sign;
          ea_d   = a[30:23];
          eb_d   = b[30:23];
          dbz_d  = 1'b0;
          if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            out_d       = QNaN;
            out_valid_d = 1'b1;
            state_d     = StDone;
          end else if (b_zero && !a_inf) begin
            out_d       = {in_sign, 8'hFF, 23'd0};
            dbz_d       = 1'b1;
            out_valid_d = 1'b1;
            state_d     = StDone;
          end else if (a_inf) begin
            out_d       = {in_sign, 8'hFF, 23'd0};
            out_valid_d = 1'b1;
            state_d     = StDone;
          end else if (a_zero || b_inf) begin
            out_d       = {in_sign, 31'd0};
            out_valid_d = 1'b1;
            state_d     = StDone;
          end else begin
            rem_d   = {2'b01, a[22:0]};
            mb_d    = {2'b01, b[22:0]};
            q_d     = '0;
            cnt_d   = 5'd24;
            state_d = StDiv;
          end
        end
      end
      StDiv: begin
        if (rem_q >= mb_q) begin
          q_d   = q_q | (25'd1 << cnt_q);
          rem_d = rem_sub << 1;
        end else begin
          rem_d = rem_q << 1;
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = StNorm;
      end
      StNorm: begin
        e = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q})
            + (q_q[24] ? 10'sd127 : 10'sd126);
        frac = q_q[24] ? q_q[23:1] : q_q[22:0];
        if (e >= 10'sd255)    out_d = {sign_q, 8'hFF, 23'd0};
        else if (e <= 10'sd0) out_d = {sign_q, 31'd0};
        else                  out_d = {sign_q, e[7:0], frac};
        dbz_d       = 1'b0;
        out_valid_d = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      mb_q        <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      ea_q        <= '0;
      eb_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      mb_q        <= mb_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      ea_q        <= ea_d;
      eb_q        <= eb_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign out         = out_q;
  assign out_valid   = out_valid_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fp_div.sv
// Self-checking bench for fp_div: expected results queued at input handshake,
// popped and compared when out_valid rises.
module tb_fp_div;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        div_by_zero;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [32:0] exp_q[$];

  fp_div #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out         (out),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Called #1 after a rising edge with the DUT idle.
  task automatic run_op(input string tag, input logic [31:0] a_v, input logic [31:0] b_v,
                        input logic [31:0] exp_out, input logic exp_dbz, input int exp_lat);
    int          lat;
    logic [32:0] exp;
    in_valid = 1'b1;
    a        = a_v;
    b        = b_v;
    exp_q.push_back({exp_dbz, exp_out});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    lat      = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_val({tag, " latency"}, 32'(lat), 32'(exp_lat));
    exp = exp_q.pop_front();
    check_val({tag, " out"}, out, exp[31:0]);
    check_val({tag, " dbz"}, {31'd0, div_by_zero}, {31'd0, exp[32]});
    if (out_ready) begin
      @(posedge clk);
      #1;
      check_val({tag, " in_ready after"}, {31'd0, in_ready}, 32'd1);
      check_val({tag, " out_valid after"}, {31'd0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] held;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    #12;
    check_val("reset in_ready", {31'd0, in_ready}, 32'd1);
    check_val("reset out_valid", {31'd0, out_valid}, 32'd0);
    check_val("reset out", out, 32'd0);
    check_val("reset dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("6/2",       32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 27);
    run_op("1/3",       32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0, 27);
    run_op("-1.5/0.5",  32'hBFC0_0000, 32'h3F00_0000, 32'hC040_0000, 1'b0, 27);
    run_op("3/1.5",     32'h4040_0000, 32'h3FC0_0000, 32'h4000_0000, 1'b0, 27);
    run_op("-1/0",      32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b1, 1);
    run_op("0/0",       32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1);
    run_op("inf/-inf",  32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1'b0, 1);
    run_op("2/inf",     32'h4000_0000, 32'h7F80_0000, 32'h0000_0000, 1'b0, 1);
    run_op("nan/1",     32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1);
    run_op("inf/0",     32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b0, 1);
    run_op("-0/5",      32'h8000_0000, 32'h40A0_0000, 32'h8000_0000, 1'b0, 1);
    run_op("overflow",  32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 1'b0, 27);
    run_op("underflow", 32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 1'b0, 27);

    // Backpressure: result must hold and further operands must be ignored.
    out_ready = 1'b0;
    run_op("bp 6/2", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 27);
    held = out;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a        = 32'h3F80_0000;
      b        = 32'h0000_0000;
      @(posedge clk);
      #1;
      check_val("bp out stable", out, held);
      check_val("bp out_valid", {31'd0, out_valid}, 32'd1);
      check_val("bp in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_val("bp release in_ready", {31'd0, in_ready}, 32'd1);
    check_val("bp release out_valid", {31'd0, out_valid}, 32'd0);
    run_op("after bp 1/3", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0, 27);

    // Reset in the middle of DIV: operation is dropped.
    in_valid = 1'b1;
    a        = 32'h40C0_0000;
    b        = 32'h4000_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_val("pre-reset in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check_val("mid reset out_valid", {31'd0, out_valid}, 32'd0);
    check_val("mid reset in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("post-reset 6/2", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 27);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
